// File: rtl/vedic_mac_pkg.sv
// vedic_mac_pkg: shared widths, defaults, FSM states and the 2x2 Vedic block
package vedic_mac_pkg;
    localparam int OPND_W    = 4;
    localparam int PROD_W    = 8;
    localparam int COUNT_DEF = 4;
    localparam int ACC_W_DEF = 10;

    typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

    // 2x2 Vedic block: vertical terms on bits 0 and 2, crosswise sum on bit 1
    function automatic logic [3:0] mul2x2(input logic [1:0] a, input logic [1:0] b);
        logic cross_c;
        cross_c = a[1] & b[0] & a[0] & b[1];
        return {a[1] & b[1] & cross_c, (a[1] & b[1]) ^ cross_c,
                (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
    endfunction
endpackage

// File: rtl/vedic_mac_acc_if.sv
// vedic_mac_acc_if: operand pair stream in, burst-sum stream out
interface vedic_mac_acc_if import vedic_mac_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF
);
    logic [OPND_W-1:0] in_a;
    logic [OPND_W-1:0] in_b;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_a, in_b, in_valid, out_ready,
        input  in_ready, out_sum, out_ovf, out_valid
    );
    modport slave (
        input  in_a, in_b, in_valid, out_ready,
        output in_ready, out_sum, out_ovf, out_valid
    );
endinterface

// File: rtl/vedic_mul4x4.sv
// vedic_mul4x4: combinational 4x4 Vedic multiplier built from four 2x2 blocks
module vedic_mul4x4 import vedic_mac_pkg::*; (
    input  logic [OPND_W-1:0] i_a,
    input  logic [OPND_W-1:0] i_b,
    output logic [PROD_W-1:0] o_p
);
    logic [3:0] w_ll, w_hl, w_lh, w_hh;
    logic [4:0] w_mid;

    assign w_ll  = mul2x2(i_a[1:0], i_b[1:0]);
    assign w_hl  = mul2x2(i_a[3:2], i_b[1:0]);
    assign w_lh  = mul2x2(i_a[1:0], i_b[3:2]);
    assign w_hh  = mul2x2(i_a[3:2], i_b[3:2]);
    assign w_mid = {1'b0, w_hl} + {1'b0, w_lh};
    assign o_p   = {w_hh, w_ll} + {1'b0, w_mid, 2'b00};
endmodule

// File: rtl/vedic_mac_acc.sv
// vedic_mac_acc: burst multiply-accumulate; define VEDIC_MAC_SAT_EN to saturate instead of wrap
module vedic_mac_acc import vedic_mac_pkg::*; #(
    parameter int COUNT = COUNT_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    vedic_mac_acc_if.slave bus
);
    state_t            r_state, w_next;
    logic [7:0]        r_beat_cnt;
    logic [PROD_W-1:0] r_prod_q, w_prod;
    logic              r_prod_v;
    logic [ACC_W-1:0]  r_acc, w_acc_d;
    logic [ACC_W:0]    w_sum;
    logic              r_ovf, w_accept, w_last, w_clr;

    vedic_mul4x4 u_mul (.i_a(bus.in_a), .i_b(bus.in_b), .o_p(w_prod));

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_last   = r_beat_cnt == 8'(COUNT - 1);
    assign w_clr    = r_state == HOLD && bus.out_ready;
    assign w_sum    = {1'b0, r_acc} + (ACC_W + 1)'(r_prod_q);
`ifdef VEDIC_MAC_SAT_EN
    assign w_acc_d  = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
    assign w_acc_d  = w_sum[ACC_W-1:0];
`endif
    assign bus.out_sum = r_acc;
    assign bus.out_ovf = r_ovf;

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ACC;
        else     r_state <= w_next;
    end

    // next state: final accept drains, drain lands in hold, consumer release returns to accumulate
    always_comb begin
        w_next = r_state == ACC   ? ((w_accept && w_last) ? DRAIN : ACC) :
                 r_state == DRAIN ? HOLD :
                 (bus.out_ready ? ACC : HOLD);
    end

    // handshake outputs decoded from registered state only
    always_comb begin
        bus.in_ready  = r_state == ACC;
        bus.out_valid = r_state == HOLD;
    end

    // product pipeline register and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod_q   <= '0;
            r_prod_v   <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_prod_v <= w_accept;
            if (w_accept) r_prod_q <= w_prod;
            if (w_clr) r_beat_cnt <= '0;
            else if (w_accept) r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    // accumulator with sticky carry-out flag, cleared when the result is taken
    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_prod_v) begin
            r_acc <= w_acc_d;
            if (w_sum[ACC_W]) r_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vedic_mac_acc.sv
// tb_vedic_mac_acc: directed vectors for the burst MAC at COUNT=4, 8 and 1
module tb_vedic_mac_acc;
    typedef struct {
        string       name;
        int          sel;
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        int          gap;
        int          sum;
        int          ovf;
    } vec_t;

`ifdef VEDIC_MAC_SAT_EN
    localparam int SUM8 = 1023;
`else
    localparam int SUM8 = 776;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drv_v = 1'b0;
    logic       drv_rdy = 1'b1;
    logic [3:0] drv_a = '0;
    logic [3:0] drv_b = '0;
    int         sel = 0;
    int         errors = 0;
    int         checks = 0;
    vec_t       vec [9];
    logic       m_in_ready, m_out_valid, m_out_ovf;
    logic [9:0] m_out_sum;

    always #5 clk = ~clk;

    vedic_mac_acc_if #(.ACC_W(10)) if4 (), if8 (), if1 ();

    assign if4.in_a = drv_a;
    assign if4.in_b = drv_b;
    assign if4.in_valid = drv_v && sel == 0;
    assign if4.out_ready = drv_rdy;
    assign if8.in_a = drv_a;
    assign if8.in_b = drv_b;
    assign if8.in_valid = drv_v && sel == 1;
    assign if8.out_ready = drv_rdy;
    assign if1.in_a = drv_a;
    assign if1.in_b = drv_b;
    assign if1.in_valid = drv_v && sel == 2;
    assign if1.out_ready = drv_rdy;

    assign m_in_ready  = (sel == 0) ? if4.in_ready  : (sel == 1) ? if8.in_ready  : if1.in_ready;
    assign m_out_valid = (sel == 0) ? if4.out_valid : (sel == 1) ? if8.out_valid : if1.out_valid;
    assign m_out_ovf   = (sel == 0) ? if4.out_ovf   : (sel == 1) ? if8.out_ovf   : if1.out_ovf;
    assign m_out_sum   = (sel == 0) ? if4.out_sum   : (sel == 1) ? if8.out_sum   : if1.out_sum;

    vedic_mac_acc #(.COUNT(4), .ACC_W(10)) u4 (.clk(clk), .rst(rst), .bus(if4));
    vedic_mac_acc #(.COUNT(8), .ACC_W(10)) u8 (.clk(clk), .rst(rst), .bus(if8));
    vedic_mac_acc #(.COUNT(1), .ACC_W(10)) u1 (.clk(clk), .rst(rst), .bus(if1));

    function automatic vec_t mk(input string nm, input int s, input int n, input logic [31:0] a,
                                input logic [31:0] b, input int g, input int sum, input int ovf);
        vec_t v;
        v.name = nm;
        v.sel  = s;
        v.n    = n;
        v.a    = a;
        v.b    = b;
        v.gap  = g;
        v.sum  = sum;
        v.ovf  = ovf;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_pair(input logic [3:0] a, input logic [3:0] b);
        int t = 0;
        drv_a = a;
        drv_b = b;
        drv_v = 1'b1;
        while (!m_in_ready && t < 20) begin
            step();
            t++;
        end
        chk("send_wait", 32'(t < 20), 1);
        step();
        drv_v = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        sel = v.sel;
        drv_rdy = 1'b1;
        for (int i = 0; i < v.n; i++) begin
            send_pair(v.a[i*4 +: 4], v.b[i*4 +: 4]);
            if (i < v.n - 1) begin
                chk({v.name, "_mid_rdy"}, 32'(m_in_ready), 1);
                chk({v.name, "_mid_vld"}, 32'(m_out_valid), 0);
                for (int g = 0; g < v.gap; g++) begin
                    drv_a = 4'hF;
                    drv_b = 4'hF;
                    step();
                end
            end
        end
        chk({v.name, "_drain_rdy"}, 32'(m_in_ready), 0);
        chk({v.name, "_drain_vld"}, 32'(m_out_valid), 0);
        step();
        chk({v.name, "_vld"}, 32'(m_out_valid), 1);
        chk({v.name, "_sum"}, 32'(m_out_sum), v.sum);
        chk({v.name, "_ovf"}, 32'(m_out_ovf), v.ovf);
        chk({v.name, "_hold_rdy"}, 32'(m_in_ready), 0);
        step();
        chk({v.name, "_ret_rdy"}, 32'(m_in_ready), 1);
        chk({v.name, "_ret_vld"}, 32'(m_out_valid), 0);
        chk({v.name, "_ret_sum"}, 32'(m_out_sum), 0);
        chk({v.name, "_ret_ovf"}, 32'(m_out_ovf), 0);
    endtask

    initial begin
        vec[0] = mk("sq4",    0, 4, 32'h0000_FFFF, 32'h0000_FFFF, 0, 900, 0);
        vec[1] = mk("big8",   1, 8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, SUM8, 1);
        vec[2] = mk("small8", 1, 8, 32'h2222_2222, 32'h3333_3333, 0, 48, 0);
        vec[3] = mk("gap4",   0, 4, 32'h0000_2703, 32'h0000_8795, 2, 80, 0);
        vec[4] = mk("one_a",  2, 1, 32'h0000_000C, 32'h0000_000D, 0, 156, 0);
        vec[5] = mk("one_b",  2, 1, 32'h0000_000F, 32'h0000_000F, 0, 225, 0);
        vec[6] = mk("one_c",  2, 1, 32'h0000_0000, 32'h0000_0007, 0, 0, 0);
        vec[7] = mk("mix4",   0, 4, 32'h0000_F531, 32'h0000_E642, 1, 254, 0);
        vec[8] = mk("post_rst", 0, 4, 32'h0000_1111, 32'h0000_1111, 0, 4, 0);

        step();
        step();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            chk("rst_rdy", 32'(m_in_ready), 1);
            chk("rst_vld", 32'(m_out_valid), 0);
            chk("rst_sum", 32'(m_out_sum), 0);
            chk("rst_ovf", 32'(m_out_ovf), 0);
        end

        for (int k = 0; k < 8; k++) run_vec(vec[k]);

        sel = 0;
        drv_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) send_pair(4'(i), 4'(i));
        step();
        chk("bp_vld", 32'(m_out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_vld", 32'(m_out_valid), 1);
            chk("bp_hold_sum", 32'(m_out_sum), 30);
            chk("bp_hold_rdy", 32'(m_in_ready), 0);
        end
        drv_rdy = 1'b1;
        step();
        chk("bp_rel_rdy", 32'(m_in_ready), 1);
        chk("bp_rel_vld", 32'(m_out_valid), 0);
        chk("bp_rel_sum", 32'(m_out_sum), 0);

        drv_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send_pair(4'hF, 4'hF);
        step();
        chk("hr_vld", 32'(m_out_valid), 1);
        chk("hr_sum", 32'(m_out_sum), 900);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("hr_rdy", 32'(m_in_ready), 1);
        chk("hr_after_vld", 32'(m_out_valid), 0);
        chk("hr_after_sum", 32'(m_out_sum), 0);
        drv_rdy = 1'b1;

        send_pair(4'd9, 4'd9);
        send_pair(4'd9, 4'd9);
        step();
        chk("mr_partial", 32'(m_out_sum), 162);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_sum", 32'(m_out_sum), 0);
        chk("mr_rdy", 32'(m_in_ready), 1);
        chk("mr_ovf", 32'(m_out_ovf), 0);
        run_vec(vec[8]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
